// File: rtl/bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_if
// Brief    : Request/strobe/grant bundle between bus masters and the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface bus_arbiter_if #(
    parameter int MASTER_CH = 4
);
    logic [MASTER_CH-1:0] m_req_;
    logic [MASTER_CH-1:0] m_as_;
    logic [MASTER_CH-1:0] m_grnt_;
    logic [1:0]           owner;
    logic                 preempt;

    modport master (
        output m_req_,
        output m_as_,
        input  m_grnt_,
        input  owner,
        input  preempt
    );

    modport slave (
        input  m_req_,
        input  m_as_,
        output m_grnt_,
        output owner,
        output preempt
    );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Brief    : Round-robin arbiter for 4 active-low masters with tenure limit.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
    parameter int MASTER_CH = 4,
    parameter int MAX_HOLD  = 16,
    parameter int HOLD_W    = 5
) (
    input  wire logic        clk,
    input  wire logic        reset,
    bus_arbiter_if.slave     bus
);

    localparam logic [HOLD_W-1:0] c_MAX_HOLD = HOLD_W'(MAX_HOLD);

    logic [1:0]           r_owner;
    logic [MASTER_CH-1:0] r_grnt_;
    logic                 r_preempt;
    logic [HOLD_W-1:0]    r_cnt;

    logic                 w_own_req;
    logic                 w_any_req;
    logic [1:0]           w_winner;
    logic                 w_force;
    logic                 w_switch;
    logic [1:0]           w_next_owner;
    logic [HOLD_W-1:0]    w_cnt_nxt;
    logic [MASTER_CH-1:0] w_grnt_nxt;

    assign w_own_req = ~bus.m_req_[r_owner];

    // Walk owner+3 down to owner+1 so the nearest requester is written last.
    always_comb begin
        logic [1:0] w_idx;
        w_winner  = r_owner;
        w_any_req = 1'b0;
        w_idx     = r_owner;
        for (int k = MASTER_CH - 1; k >= 1; k--) begin
            w_idx = r_owner + 2'(k);
            if (bus.m_req_[w_idx] == 1'b0) begin
                w_winner  = w_idx;
                w_any_req = 1'b1;
            end
        end
    end

    assign w_force = (MAX_HOLD != 0) && (r_cnt == c_MAX_HOLD) && w_own_req
                   && w_any_req && (bus.m_as_[r_owner] == 1'b1);

    assign w_switch     = (!w_own_req && w_any_req) || w_force;
    assign w_next_owner = w_switch ? w_winner : r_owner;

    // Tenure only accrues while the owner holds against real competition.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_switch || !w_own_req || !w_any_req) begin
            w_cnt_nxt = '0;
        end else if (r_cnt != c_MAX_HOLD) begin
            w_cnt_nxt = r_cnt + HOLD_W'(1);
        end
    end

    always_comb begin
        w_grnt_nxt               = '1;
        w_grnt_nxt[w_next_owner] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner   <= 2'd0;
            r_grnt_   <= {{(MASTER_CH-1){1'b1}}, 1'b0};
            r_preempt <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_owner   <= w_next_owner;
            r_grnt_   <= w_grnt_nxt;
            r_preempt <= w_force;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign bus.m_grnt_ = r_grnt_;
    assign bus.owner   = r_owner;
    assign bus.preempt = r_preempt;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Brief    : Directed self-checking bench for bus_arbiter (MAX_HOLD 4 and 0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    bus_arbiter_if #(.MASTER_CH(4)) bus4 ();
    bus_arbiter_if #(.MASTER_CH(4)) bus0 ();

    bus_arbiter #(.MASTER_CH(4), .MAX_HOLD(4), .HOLD_W(3)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    bus_arbiter #(.MASTER_CH(4), .MAX_HOLD(0), .HOLD_W(1)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [1:0] eo, input logic ep);
        logic [3:0] eg;
        eg = 4'b1111 ^ (4'b0001 << eo);
        chk({tag, "/grnt"},    8'(bus4.m_grnt_), 8'(eg));
        chk({tag, "/owner"},   8'(bus4.owner),   8'(eo));
        chk({tag, "/preempt"}, 8'(bus4.preempt), 8'(ep));
    endtask

    task automatic chk0(input string tag, input logic [1:0] eo, input logic ep);
        logic [3:0] eg;
        eg = 4'b1111 ^ (4'b0001 << eo);
        chk({tag, "/grnt"},    8'(bus0.m_grnt_), 8'(eg));
        chk({tag, "/owner"},   8'(bus0.owner),   8'(eo));
        chk({tag, "/preempt"}, 8'(bus0.preempt), 8'(ep));
    endtask

    initial begin
        reset       = 1'b1;
        bus4.m_req_ = 4'b1111;
        bus4.m_as_  = 4'b1111;
        bus0.m_req_ = 4'b1111;
        bus0.m_as_  = 4'b1111;
        repeat (2) tick();
        chk4("reset", 2'd0, 1'b0);
        chk0("reset0", 2'd0, 1'b0);

        // Idle park; non-owner strobes unknown must not disturb anything.
        reset      = 1'b0;
        bus4.m_as_ = 4'bxxx1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk4("idle", 2'd0, 1'b0);
        end
        bus4.m_as_ = 4'b1111;

        // Voluntary handover 0 -> 2, then 2 keeps the bus against 0.
        bus4.m_req_ = 4'b1110; tick(); chk4("hold0", 2'd0, 1'b0);
        bus4.m_req_ = 4'b1010;
        tick(); chk4("hold0_req2_a", 2'd0, 1'b0);
        tick(); chk4("hold0_req2_b", 2'd0, 1'b0);
        bus4.m_req_ = 4'b1011; tick(); chk4("handover2", 2'd2, 1'b0);
        bus4.m_req_ = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk4("hold2", 2'd2, 1'b0);
        end
        bus4.m_req_ = 4'b1110; tick(); chk4("release2", 2'd0, 1'b0);

        // Fairness: 1 releases with 0,2,3 waiting -> 2, 3, then wrap to 0.
        bus4.m_req_ = 4'b1101; tick(); chk4("to1",   2'd1, 1'b0);
        bus4.m_req_ = 4'b0010; tick(); chk4("rr_2",  2'd2, 1'b0);
        bus4.m_req_ = 4'b0110; tick(); chk4("rr_3",  2'd3, 1'b0);
        bus4.m_req_ = 4'b1110; tick(); chk4("rr_0",  2'd0, 1'b0);

        // Tenure: master 1 waits; rotation lands on the fifth edge.
        bus4.m_req_ = 4'b1100;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk4("tenure_wait", 2'd0, 1'b0);
        end
        tick(); chk4("tenure_rot",   2'd1, 1'b1);
        tick(); chk4("tenure_after", 2'd1, 1'b0);

        // Deferred rotation while owner 0 keeps its strobe low.
        bus4.m_req_ = 4'b1110; tick(); chk4("back0", 2'd0, 1'b0);
        bus4.m_as_  = 4'b1110;
        bus4.m_req_ = 4'b1100;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk4("defer_wait", 2'd0, 1'b0);
        end
        bus4.m_as_ = 4'b1111;
        tick(); chk4("defer_rot",   2'd1, 1'b1);
        tick(); chk4("defer_after", 2'd1, 1'b0);

        // Reset while owner 3 has accrued tenure.
        bus4.m_req_ = 4'b0111; tick(); chk4("to3", 2'd3, 1'b0);
        bus4.m_req_ = 4'b0101;
        repeat (2) tick();
        chk4("hold3", 2'd3, 1'b0);
        reset = 1'b1;
        tick(); chk4("reset_mid", 2'd0, 1'b0);
        reset       = 1'b0;
        bus4.m_req_ = 4'b1100;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk4("post_reset_wait", 2'd0, 1'b0);
        end
        tick(); chk4("post_reset_rot", 2'd1, 1'b1);

        // MAX_HOLD=0: master 0 holds forever despite master 1 waiting.
        bus0.m_req_ = 4'b1100;
        for (int i = 0; i < 100; i++) begin
            tick();
            chk0("nolimit", 2'd0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
